fetch_align_buffer: RTL and testbench

Fetch-stage byte aligner that sits directly upstream of `decode_top`. It requests 16-byte-aligned lines from instruction memory and packs them into a 32-byte window that always starts at the current fetch PC. It presents the window on the `f_*` interface and retires however many bytes decode reports as consumed. It also handles flush redirects, discarding any stale line that is still in flight.

---
 rtl/fetch_align_buffer.sv | 122 ++++++++++++
 tb/tb_fetch_align_buffer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_align_buffer.sv
// Fetch-stage aligner: requests 16-byte lines and packs them into a 32-byte
// window that always begins at the current fetch PC.
module fetch_align_buffer #(
  parameter int                IDATAW   = 128,
  parameter int                IADDRW   = 32,
  parameter logic [IADDRW-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic [IADDRW-1:0] flush_pc,
  input  logic              halt,
  output logic              im_req_valid,
  input  logic              im_req_ready,
  output logic [IADDRW-1:0] im_req_addr,
  input  logic              im_rsp_valid,
  input  logic [IDATAW-1:0] im_rsp_data,
  output logic              f_valid,
  input  logic              f_ready,
  input  logic [5:0]        f_bytes_read,
  output logic [5:0]        f_valid_bytes,
  output logic [255:0]      f_instruction,
  output logic [IADDRW-1:0] f_pc,
  output logic              f_branch_taken
);

  logic [255:0]      win_reg, win_next;
  logic [5:0]        count_reg, count_next;
  logic [IADDRW-1:0] pc_reg, pc_next;
  logic [IADDRW-1:0] fetch_addr_reg, fetch_addr_next;
  logic [3:0]        skip_reg, skip_next;
  logic              outstanding_reg, outstanding_next;
  logic              drop_reg, drop_next;
  logic              req_valid_reg, req_valid_next;

  logic              fire;
  logic              keep;
  logic [5:0]        consume_n;
  logic [5:0]        count_after;
  logic [5:0]        rsp_len;
  logic [255:0]      shifted;
  logic [IDATAW-1:0] rsp_bytes;
  logic [255:0]      rsp_placed;

  always_comb begin
    fire        = req_valid_reg && im_req_ready;
    keep        = im_rsp_valid && !drop_reg;
    consume_n   = 6'd0;
    // Over-reporting is clamped to the window; zero means no consume.
    if (count_reg != 6'd0 && f_ready)
      consume_n = (f_bytes_read > count_reg) ? count_reg : f_bytes_read;
    count_after = count_reg - consume_n;
    shifted     = win_reg >> {consume_n, 3'b000};
    rsp_bytes   = im_rsp_data >> {skip_reg, 3'b000};
    rsp_len     = 6'd16 - {2'b00, skip_reg};
    rsp_placed  = {{(256-IDATAW){1'b0}}, rsp_bytes} << {count_after, 3'b000};

    win_next         = win_reg;
    count_next       = count_reg;
    pc_next          = pc_reg;
    fetch_addr_next  = fetch_addr_reg;
    skip_next        = skip_reg;
    outstanding_next = (outstanding_reg && !im_rsp_valid) || fire;
    drop_next        = drop_reg;
    req_valid_next   = 1'b0;

    if (flush) begin
      win_next        = '0;
      count_next      = 6'd0;
      pc_next         = flush_pc;
      fetch_addr_next = {flush_pc[IADDRW-1:4], 4'b0000};
      skip_next       = flush_pc[3:0];
      // Whatever is still in flight now belongs to the old stream.
      drop_next       = outstanding_next;
      req_valid_next  = !outstanding_next && !halt;
    end else begin
      win_next   = keep ? (shifted | rsp_placed) : shifted;
      count_next = keep ? (count_after + rsp_len) : count_after;
      pc_next    = pc_reg + {{(IADDRW-6){1'b0}}, consume_n};
      if (keep)
        skip_next = 4'd0;
      if (fire)
        fetch_addr_next = fetch_addr_reg + IADDRW'(16);
      if (im_rsp_valid)
        drop_next = 1'b0;
      // A raised request is held until accepted, even if halt rises.
      req_valid_next = (req_valid_reg && !fire) ||
                       (!outstanding_next && !halt && count_next <= 6'd16);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      win_reg         <= '0;
      count_reg       <= 6'd0;
      pc_reg          <= RESET_PC;
      fetch_addr_reg  <= {RESET_PC[IADDRW-1:4], 4'b0000};
      skip_reg        <= RESET_PC[3:0];
      outstanding_reg <= 1'b0;
      drop_reg        <= 1'b0;
      req_valid_reg   <= 1'b0;
    end else begin
      win_reg         <= win_next;
      count_reg       <= count_next;
      pc_reg          <= pc_next;
      fetch_addr_reg  <= fetch_addr_next;
      skip_reg        <= skip_next;
      outstanding_reg <= outstanding_next;
      drop_reg        <= drop_next;
      req_valid_reg   <= req_valid_next;
    end
  end

  assign im_req_valid   = req_valid_reg;
  assign im_req_addr    = fetch_addr_reg;
  assign f_valid        = (count_reg != 6'd0);
  assign f_valid_bytes  = count_reg;
  assign f_instruction  = win_reg;
  assign f_pc           = pc_reg;
  assign f_branch_taken = 1'b0;

endmodule

// File: tb/tb_fetch_align_buffer.sv
// Directed bench for fetch_align_buffer; memory byte at address a holds a[7:0].
module tb_fetch_align_buffer;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic [31:0]  flush_pc = '0;
  logic         halt = 1'b0;
  logic         im_req_valid;
  logic         im_req_ready = 1'b1;
  logic [31:0]  im_req_addr;
  logic         im_rsp_valid;
  logic [127:0] im_rsp_data;
  logic         f_valid;
  logic         f_ready = 1'b0;
  logic [5:0]   f_bytes_read = '0;
  logic [5:0]   f_valid_bytes;
  logic [255:0] f_instruction;
  logic [31:0]  f_pc;
  logic         f_branch_taken;

  int passed = 0;
  int total = 0;
  int lat = 1;

  logic        pend;
  int          pcnt;
  logic [31:0] paddr;
  logic [31:0] rsp_addr;

  always #5 clk = ~clk;

  fetch_align_buffer #(.IDATAW(128), .IADDRW(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .flush_pc(flush_pc), .halt(halt),
    .im_req_valid(im_req_valid), .im_req_ready(im_req_ready), .im_req_addr(im_req_addr),
    .im_rsp_valid(im_rsp_valid), .im_rsp_data(im_rsp_data),
    .f_valid(f_valid), .f_ready(f_ready), .f_bytes_read(f_bytes_read),
    .f_valid_bytes(f_valid_bytes), .f_instruction(f_instruction), .f_pc(f_pc),
    .f_branch_taken(f_branch_taken)
  );

  function automatic logic [127:0] line_of(input logic [31:0] a);
    logic [127:0] d;
    logic [31:0]  b;
    d = '0;
    for (int k = 0; k < 16; k++) begin
      b = a + k;
      d[8*k +: 8] = b[7:0];
    end
    return d;
  endfunction

  // In-order memory model with a programmable response latency.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend         <= 1'b0;
      pcnt         <= 0;
      paddr        <= '0;
      rsp_addr     <= '0;
      im_rsp_valid <= 1'b0;
      im_rsp_data  <= '0;
    end else begin
      im_rsp_valid <= 1'b0;
      if (pend) begin
        if (pcnt == 0) begin
          im_rsp_valid <= 1'b1;
          im_rsp_data  <= line_of(paddr);
          rsp_addr     <= paddr;
          pend         <= 1'b0;
        end else begin
          pcnt <= pcnt - 1;
        end
      end
      if (im_req_valid && im_req_ready) begin
        pend  <= 1'b1;
        paddr <= im_req_addr;
        pcnt  <= lat - 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] wbyte(input int k);
    return f_instruction[8*k +: 8];
  endfunction

  task automatic wait_nonzero(input string tag, input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (f_valid_bytes != 6'd0) break;
      tick();
    end
    check(tag, 64'(i < limit), 64'd1);
  endtask

  task automatic do_flush(input logic [31:0] target);
    flush = 1'b1;
    flush_pc = target;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    logic saw_stale;
    logic any_req;
    int   i;

    // 1. Reset state and fill
    #2;
    check("rst_f_valid", 64'(f_valid), 64'd0);
    check("rst_valid_bytes", 64'(f_valid_bytes), 64'd0);
    check("rst_pc", 64'(f_pc), 64'h0);
    check("rst_req_valid", 64'(im_req_valid), 64'd0);
    tick();
    reset = 1'b1;
    tick();
    check("req_after_reset", 64'(im_req_valid), 64'd1);
    check("req_addr_first", 64'(im_req_addr), 64'h0);
    for (i = 0; i < 30; i++) begin
      if (f_valid_bytes == 6'd32) break;
      tick();
    end
    check("fill_bytes", 64'(f_valid_bytes), 64'd32);
    check("fill_byte0", 64'(wbyte(0)), 64'h00);
    check("fill_byte16", 64'(wbyte(16)), 64'h10);
    any_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      any_req = any_req | im_req_valid;
    end
    check("fill_no_req", 64'(any_req), 64'd0);

    // 2. Consume (zero consume is a no-op)
    f_ready = 1'b1; f_bytes_read = 6'd0;
    tick();
    check("zero_consume", 64'(f_valid_bytes), 64'd32);
    f_bytes_read = 6'd5;
    tick();
    f_ready = 1'b0;
    check("c5_pc", 64'(f_pc), 64'd5);
    check("c5_bytes", 64'(f_valid_bytes), 64'd27);
    check("c5_byte0", 64'(wbyte(0)), 64'h05);
    check("c5_no_req", 64'(im_req_valid), 64'd0);
    im_req_ready = 1'b0;
    f_ready = 1'b1; f_bytes_read = 6'd11;
    tick();
    f_ready = 1'b0;
    check("c11_bytes", 64'(f_valid_bytes), 64'd16);
    check("c11_byte0", 64'(wbyte(0)), 64'h10);
    check("c11_req", 64'(im_req_valid), 64'd1);
    check("c11_addr", 64'(im_req_addr), 64'h20);

    // 3. Redirect to an unaligned target; pending request is withdrawn
    do_flush(32'h1003);
    im_req_ready = 1'b1;
    check("fl_f_valid", 64'(f_valid), 64'd0);
    check("fl_req", 64'(im_req_valid), 64'd1);
    check("fl_addr", 64'(im_req_addr), 64'h1000);
    wait_nonzero("fl_timeout", 20);
    check("fl_bytes", 64'(f_valid_bytes), 64'd13);
    check("fl_pc", 64'(f_pc), 64'h1003);
    check("fl_byte0", 64'(wbyte(0)), 64'h03);
    check("fl_byte12", 64'(wbyte(12)), 64'h0F);

    // 4. Stale drop: flush while the 0x40 request is in flight
    lat = 4;
    do_flush(32'h30);
    for (i = 0; i < 60; i++) begin
      if (im_req_valid && im_req_addr == 32'h40) break;
      tick();
    end
    check("req40_timeout", 64'(i < 60), 64'd1);
    tick();
    do_flush(32'h2000);
    saw_stale = 1'b0;
    for (i = 0; i < 60; i++) begin
      if (im_rsp_valid && rsp_addr == 32'h40) saw_stale = 1'b1;
      if (f_valid_bytes != 6'd0) break;
      tick();
    end
    check("stale_timeout", 64'(i < 60), 64'd1);
    check("stale_seen", 64'(saw_stale), 64'd1);
    check("stale_bytes", 64'(f_valid_bytes), 64'd16);
    check("stale_pc", 64'(f_pc), 64'h2000);
    check("stale_byte0", 64'(wbyte(0)), 64'h00);
    check("stale_byte15", 64'(wbyte(15)), 64'h0F);

    // 5. Consume and append in the same cycle
    lat = 1;
    do_flush(32'h3006);
    wait_nonzero("sim_fill_timeout", 30);
    check("sim_count10", 64'(f_valid_bytes), 64'd10);
    for (i = 0; i < 10; i++) begin
      if (im_rsp_valid) break;
      tick();
    end
    check("sim_rsp_timeout", 64'(i < 10), 64'd1);
    f_ready = 1'b1; f_bytes_read = 6'd4;
    tick();
    f_ready = 1'b0;
    check("sim_bytes", 64'(f_valid_bytes), 64'd22);
    check("sim_pc", 64'(f_pc), 64'h300A);
    check("sim_byte0", 64'(wbyte(0)), 64'h0A);
    check("sim_byte5", 64'(wbyte(5)), 64'h0F);
    check("sim_byte6", 64'(wbyte(6)), 64'h10);
    check("sim_byte21", 64'(wbyte(21)), 64'h1F);

    // 6. Asynchronous reset mid-request, then halt
    do_flush(32'h5000);
    tick();
    #1 reset = 1'b0;
    halt = 1'b1;
    #1;
    check("ar_f_valid", 64'(f_valid), 64'd0);
    check("ar_bytes", 64'(f_valid_bytes), 64'd0);
    check("ar_instr", 64'(|f_instruction), 64'd0);
    check("ar_pc", 64'(f_pc), 64'h0);
    check("ar_req", 64'(im_req_valid), 64'd0);
    check("ar_branch", 64'(f_branch_taken), 64'd0);
    tick();
    reset = 1'b1;
    any_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      any_req = any_req | im_req_valid;
    end
    check("halt_no_req", 64'(any_req), 64'd0);
    halt = 1'b0;
    tick();
    check("unhalt_req", 64'(im_req_valid), 64'd1);
    check("unhalt_addr", 64'(im_req_addr), 64'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
